// File: rtl/bsg_sf_arb_pkg.sv
// Shared types for the store-and-forward packet arbiter.
// Arbiter states plus a clog2 helper that never returns zero.
package bsg_sf_arb_pkg;

  typedef enum logic [1:0] {
    e_idle,
    e_locked,
    e_abort,
    e_drain
  } state_e;

  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bsg_sf_packet_arbiter_if.sv
// Source-side and downstream handshake bundle of the arbiter.
// slave is the arbiter view, master the view of whoever drives it.
interface bsg_sf_packet_arbiter_if #(
  parameter int num_in_p = 4,
  parameter int width_p  = 32
);
  import bsg_sf_arb_pkg::*;

  localparam int lg_num_in_lp = safe_clog2(num_in_p);

  logic [num_in_p-1:0]         v_i;
  logic [num_in_p*width_p-1:0] data_i;
  logic [num_in_p-1:0]         last_i;
  logic [num_in_p-1:0]         error_i;
  logic [num_in_p-1:0]         ready_o;
  logic                        v_o;
  logic [width_p-1:0]          data_o;
  logic                        last_o;
  logic                        error_o;
  logic                        ready_i;
  logic [lg_num_in_lp-1:0]     grant_id_o;
  logic                        locked_o;
  logic                        timeout_o;

  modport slave (
    input  v_i, data_i, last_i, error_i, ready_i,
    output ready_o, v_o, data_o, last_o, error_o,
    output grant_id_o, locked_o, timeout_o
  );

  modport master (
    output v_i, data_i, last_i, error_i, ready_i,
    input  ready_o, v_o, data_o, last_o, error_o,
    input  grant_id_o, locked_o, timeout_o
  );

endinterface

// File: rtl/bsg_sf_rr_pick.sv
// Circular priority pick: first requester at or after the pointer.
// Purely combinational; the owner registers the pointer.
module bsg_sf_rr_pick #(
  parameter int num_in_p     = 4,
  parameter int lg_num_in_lp = 2
) (
  input  logic [num_in_p-1:0]     req_i,
  input  logic [lg_num_in_lp-1:0] ptr_i,
  output logic [lg_num_in_lp-1:0] id_o,
  output logic                    v_o
);

  int idx;

  // Walk farthest-to-nearest so the nearest requester wins last.
  always_comb begin
    id_o = '0;
    v_o  = 1'b0;
    idx  = 0;
    for (int i = num_in_p - 1; i >= 0; i--) begin
      idx = (int'(ptr_i) + i) % num_in_p;
      if (req_i[idx]) begin
        v_o  = 1'b1;
        id_o = lg_num_in_lp'(idx);
      end
    end
  end

endmodule

// File: rtl/bsg_sf_packet_arbiter.sv
// Packet-granular round-robin arbiter in front of a store-and-forward FIFO.
// Stalled packets are cut off by a watchdog that injects an error beat.
module bsg_sf_packet_arbiter
  import bsg_sf_arb_pkg::*;
#(
  parameter int num_in_p  = 4,
  parameter int width_p   = 32,
  parameter int timeout_p = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_sf_packet_arbiter_if.slave  io
);

  localparam int lg_num_in_lp = safe_clog2(num_in_p);
  localparam int cnt_w_lp     = safe_clog2(timeout_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_max_lp = {cnt_w_lp{1'b1}};
  localparam logic [cnt_w_lp-1:0] cnt_to_lp  = cnt_w_lp'(timeout_p);
  localparam logic [lg_num_in_lp-1:0] last_id_lp = lg_num_in_lp'(num_in_p - 1);

  state_e                  state_q, state_d;
  logic [lg_num_in_lp-1:0] ptr_q, ptr_d;
  logic [lg_num_in_lp-1:0] gnt_q, gnt_d;
  logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
  logic                    to_q, to_d;

  logic [lg_num_in_lp-1:0] win;
  logic [lg_num_in_lp-1:0] sel;
  logic                    any_v;
  logic                    sel_v;
  logic                    sel_last;
  logic                    sel_err;
  logic [width_p-1:0]      sel_data;

  logic [num_in_p-1:0]     rdy;
  logic                    out_v;
  logic [width_p-1:0]      out_data;
  logic                    out_last;
  logic                    out_err;

  function automatic logic [lg_num_in_lp-1:0] nxt(
    input logic [lg_num_in_lp-1:0] id
  );
    return (id == last_id_lp) ? '0 : id + 1'b1;
  endfunction

  bsg_sf_rr_pick #(
    .num_in_p     (num_in_p),
    .lg_num_in_lp (lg_num_in_lp)
  ) pick (
    .req_i (io.v_i),
    .ptr_i (ptr_q),
    .id_o  (win),
    .v_o   (any_v)
  );

  assign sel      = (state_q == e_idle) ? win : gnt_q;
  assign sel_v    = io.v_i[sel];
  assign sel_last = io.last_i[sel];
  assign sel_err  = io.error_i[sel];
  assign sel_data = io.data_i[int'(sel)*width_p +: width_p];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    to_d     = 1'b0;
    rdy      = '0;
    out_v    = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    out_err  = 1'b0;
    unique case (state_q)
      e_idle: begin
        if (any_v) begin
          out_v    = 1'b1;
          out_data = sel_data;
          out_last = sel_last;
          out_err  = sel_err;
          rdy[win] = io.ready_i;
          if (io.ready_i) begin
            gnt_d = win;
            if (sel_last) begin
              ptr_d = nxt(win);
            end else begin
              state_d = e_locked;
              cnt_d   = '0;
            end
          end
        end
      end
      e_locked: begin
        out_v      = sel_v;
        out_data   = sel_data;
        out_last   = sel_last;
        out_err    = sel_err;
        rdy[gnt_q] = io.ready_i;
        // Backpressure with a valid source keeps the watchdog clear.
        if (sel_v) begin
          cnt_d = '0;
          if (io.ready_i && sel_last) begin
            state_d = e_idle;
            ptr_d   = nxt(gnt_q);
          end
        end else begin
          if (cnt_q != cnt_max_lp) cnt_d = cnt_q + cnt_w_lp'(1);
          if (timeout_p != 0 && cnt_d == cnt_to_lp) state_d = e_abort;
        end
      end
      e_abort: begin
        out_v    = 1'b1;
        out_last = 1'b1;
        out_err  = 1'b1;
        if (io.ready_i) begin
          state_d = e_drain;
          to_d    = 1'b1;
        end
      end
      e_drain: begin
        rdy[gnt_q] = 1'b1;
        if (sel_v && sel_last) begin
          state_d = e_idle;
          ptr_d   = nxt(gnt_q);
        end
      end
      default: state_d = e_idle;
    endcase
    if (!reset_n_i) begin
      out_v = 1'b0;
      rdy   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_idle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign io.ready_o    = rdy;
  assign io.v_o        = out_v;
  assign io.data_o     = out_data;
  assign io.last_o     = out_last;
  assign io.error_o    = out_err;
  assign io.grant_id_o = gnt_q;
  assign io.locked_o   = (state_q != e_idle);
  assign io.timeout_o  = to_q;

endmodule

// File: tb/tb_bsg_sf_packet_arbiter.sv
// Randomized scoreboard bench for bsg_sf_packet_arbiter.
// Packet-level round-robin model feeds an expected-beat queue.
module tb_bsg_sf_packet_arbiter;
  import bsg_sf_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic         e;
    int           gap;
  } beat_t;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
    logic         e;
    logic         chk;
    int           g;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  always #5 clk = ~clk;

  bsg_sf_packet_arbiter_if #(.num_in_p(N), .width_p(W)) bus ();
  bsg_sf_packet_arbiter_if #(.num_in_p(N), .width_p(W)) bus2 ();

  bsg_sf_packet_arbiter #(
    .num_in_p(N), .width_p(W), .timeout_p(4)
  ) dut (
    .clk_i(clk), .reset_n_i(rst_n), .io(bus)
  );

  bsg_sf_packet_arbiter #(
    .num_in_p(N), .width_p(W), .timeout_p(0)
  ) dut_nowd (
    .clk_i(clk), .reset_n_i(rst2_n), .io(bus2)
  );

  int total = 0;
  int bad = 0;

  beat_t sq[N][$];
  beat_t mb[N][$];
  int    pl[N][$];
  int    pa[N][$];
  exp_t  eq[$];
  exp_t  me;
  int    ptr_m = 0;
  int    aborts_exp = 0;
  int    to_seen = 0;
  int    multi_rdy = 0;
  int    rdy_mode = 1;
  bit    saw_locked = 0;
  bit    stall_on = 0;
  bit    stall_have = 0;
  logic [W-1:0] stall_d;
  int    stall_bad = 0;

  task automatic check(string nm, longint act, longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  function automatic bit busy();
    bit b = (eq.size() > 0);
    for (int k = 0; k < N; k++) if (sq[k].size() > 0) b = 1;
    return b;
  endfunction

  task automatic add_pkt(int k, int len, int ab, int gmax);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.d   = {8'(k), 24'($urandom)};
      b.l   = (j == len - 1);
      b.e   = b.l && ($urandom_range(0, 3) == 0);
      b.gap = (j == ab) ? 10 : ((j > 0) ? $urandom_range(0, gmax) : 0);
      sq[k].push_back(b);
      mb[k].push_back(b);
    end
    pl[k].push_back(len);
    pa[k].push_back(ab);
  endtask

  // Whole packets are granted in circular order; aborted ones end early.
  task automatic model_run();
    exp_t  e;
    beat_t b;
    int    w, len, ab;
    bit    done = 0;
    while (!done) begin
      w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && pl[(ptr_m + i) % N].size() > 0) w = (ptr_m + i) % N;
      if (w < 0) begin
        done = 1;
      end else begin
        len = pl[w].pop_front();
        ab  = pa[w].pop_front();
        for (int j = 0; j < len; j++) begin
          b = mb[w].pop_front();
          if (ab < 0 || j < ab) begin
            e.d = b.d; e.l = b.l; e.e = b.e; e.chk = (j > 0); e.g = w;
            eq.push_back(e);
          end else if (j == ab) begin
            e.d = '0; e.l = 1; e.e = 1; e.chk = 1; e.g = w;
            eq.push_back(e);
            aborts_exp++;
          end
        end
        ptr_m = (w + 1) % N;
      end
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.v_i[k] = 0;
      bus.last_i[k] = 0;
      bus.error_i[k] = 0;
      bus.data_i[k*W +: W] = '0;
      if (sq[k].size() > 0) begin
        if (sq[k][0].gap > 0) begin
          sq[k][0].gap--;
        end else begin
          bus.v_i[k] = 1;
          bus.last_i[k] = sq[k][0].l;
          bus.error_i[k] = sq[k][0].e;
          bus.data_i[k*W +: W] = sq[k][0].d;
        end
      end
    end
    case (rdy_mode)
      0: bus.ready_i = ($urandom_range(0, 9) < 7);
      1: bus.ready_i = 1'b1;
      default: bus.ready_i = 1'b0;
    endcase
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < N; k++)
      if (rst_n && bus.v_i[k] && bus.ready_o[k]) sq[k].delete(0);
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(string nm, int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    total++;
    if (busy()) begin
      bad++;
      $display("FAIL %s: timed out after %0d cycles, %0d beats outstanding",
               nm, n, eq.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.locked_o) saw_locked = 1;
      if (bus.timeout_o) to_seen++;
      if ($countones(bus.ready_o) > 1) multi_rdy++;
      if (stall_on) begin
        if (!stall_have) begin
          stall_d = bus.data_o;
          stall_have = 1;
        end else if (bus.data_o !== stall_d) begin
          stall_bad++;
        end
        if (bus.ready_o != '0 || !bus.v_o || bus.timeout_o) stall_bad++;
      end
      if (bus.v_o && bus.ready_i) begin
        total++;
        if (eq.size() == 0) begin
          bad++;
          $display("FAIL beat: unexpected beat data=%h last=%b err=%b",
                   bus.data_o, bus.last_o, bus.error_o);
        end else begin
          me = eq.pop_front();
          if (bus.data_o !== me.d || bus.last_o !== me.l ||
              bus.error_o !== me.e ||
              (me.chk && int'(bus.grant_id_o) != me.g)) begin
            bad++;
            $display("FAIL beat: got d=%h l=%b e=%b g=%0d expected d=%h l=%b e=%b g=%0d",
                     bus.data_o, bus.last_o, bus.error_o, bus.grant_id_o,
                     me.d, me.l, me.e, me.g);
          end
        end
      end
    end
  end

  initial begin
    int n, to0, nv, nu, nt;
    bus.v_i = '1; bus.last_i = '1; bus.error_i = '0;
    bus.data_i = '1; bus.ready_i = 1'b1;
    bus2.v_i = '0; bus2.last_i = '0; bus2.error_i = '0;
    bus2.data_i = '0; bus2.ready_i = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_v_o", bus.v_o, 0);
    check("rst_ready_o", bus.ready_o, 0);
    check("rst_grant", bus.grant_id_o, 0);
    check("rst_locked", bus.locked_o, 0);
    check("rst_timeout", bus.timeout_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) add_pkt(k, 3, -1, 0);
    model_run();
    rdy_mode = 1;
    drive();
    run("three_pkts", 200);

    for (int r = 0; r < 2; r++)
      for (int k = 0; k < N; k++) add_pkt(k, 1, -1, 0);
    model_run();
    saw_locked = 0;
    run("single_beats", 200);
    check("single_no_lock", saw_locked, 0);

    to0 = to_seen;
    add_pkt(1, 4, 2, 0);
    add_pkt(3, 2, -1, 0);
    model_run();
    rdy_mode = 0;
    run("abort", 400);
    check("abort_pulses", to_seen - to0, 1);

    to0 = to_seen;
    add_pkt(0, 4, -1, 0);
    model_run();
    rdy_mode = 1;
    n = 0;
    while (!bus.locked_o && n < 20) begin step(); n++; end
    check("stall_locked", bus.locked_o, 1);
    check("stall_grant", bus.grant_id_o, 0);
    add_pkt(2, 2, -1, 0);
    model_run();
    rdy_mode = 2;
    bus.ready_i = 1'b0;
    stall_on = 1;
    repeat (100) step();
    stall_on = 0;
    check("stall_clean", stall_bad, 0);
    check("stall_no_abort", to_seen - to0, 0);
    check("stall_still_locked", bus.locked_o, 1);
    rdy_mode = 0;
    run("stall_release", 400);

    for (int p = 0; p < 40; p++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int q = 0; q < $urandom_range(1, 2); q++) begin
            int len = $urandom_range(1, 5);
            int ab = (len >= 2 && $urandom_range(0, 4) == 0) ?
                     $urandom_range(1, len - 1) : -1;
            add_pkt(k, len, ab, 2);
          end
        end
      end
      model_run();
      run("random", 3000);
    end

    rdy_mode = 1;
    add_pkt(2, 4, -1, 0);
    model_run();
    n = 0;
    while (sq[2].size() > 2 && n < 40) begin step(); n++; end
    check("rst_mid_reached", sq[2].size(), 2);
    rst_n = 1'b0;
    for (int k = 0; k < N; k++) begin
      sq[k].delete(); mb[k].delete(); pl[k].delete(); pa[k].delete();
    end
    eq.delete();
    ptr_m = 0;
    bus.v_i = '1;
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("rst_mid_v_o", bus.v_o, 0);
    check("rst_mid_ready", bus.ready_o, 0);
    @(posedge clk);
    #1;
    bus.v_i = '0;
    rst_n = 1'b1;
    check("rst_mid_locked", bus.locked_o, 0);
    check("rst_mid_grant", bus.grant_id_o, 0);
    add_pkt(3, 2, -1, 0);
    add_pkt(0, 1, -1, 0);
    model_run();
    rdy_mode = 0;
    drive();
    run("after_reset", 200);

    check("timeout_total", to_seen, aborts_exp);
    check("ready_onehot", multi_rdy, 0);

    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    bus2.v_i = 4'b0100;
    bus2.data_i[2*W +: W] = 32'hC0FFEE02;
    bus2.last_i = '0;
    @(posedge clk);
    #1;
    bus2.v_i = '0;
    check("nowd_locked", bus2.locked_o, 1);
    check("nowd_grant", bus2.grant_id_o, 2);
    nv = 0; nu = 0; nt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus2.v_o) nv++;
      if (!bus2.locked_o) nu++;
      if (bus2.timeout_o) nt++;
    end
    check("nowd_no_beat", nv, 0);
    check("nowd_stays_locked", nu, 0);
    check("nowd_no_timeout", nt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
